// File: rtl/cv_baud_gen_if.sv
// Control/status bundle between the UART cores and the baud timing generator.
// Latency: n/a (wires only). Backpressure: none, strobes are fire-and-forget.
interface cv_baud_gen_if #(
  parameter int CNT_WDT  = 16,
  parameter int FRAC_WDT = 4
);
  logic                EN;
  logic [CNT_WDT-1:0]  DIV_IN;
  logic [FRAC_WDT-1:0] FRAC_IN;
  logic                DIV_WE;
  logic                RESYNC;
  logic                OVS_CE;
  logic                UART_CE;
  logic                MID_CE;
  logic                LOAD_PEND;
  logic [CNT_WDT-1:0]  DIV_ACTIVE;

  modport master (
    output EN, DIV_IN, FRAC_IN, DIV_WE, RESYNC,
    input  OVS_CE, UART_CE, MID_CE, LOAD_PEND, DIV_ACTIVE
  );

  modport slave (
    input  EN, DIV_IN, FRAC_IN, DIV_WE, RESYNC,
    output OVS_CE, UART_CE, MID_CE, LOAD_PEND, DIV_ACTIVE
  );
endinterface

// File: rtl/cv_baud_gen.sv
// UART timing: fractional prescaler driving oversample, bit and mid-bit strobes.
// Latency: strobes registered, one cycle after the wrapping edge. Backpressure: none; EN=0 freezes counting.
module cv_baud_gen #(
  parameter int CNT_WDT      = 16,
  parameter int FRAC_WDT     = 4,
  parameter int OVS_RATE     = 16,
  parameter int OVS_WDT      = 4,
  parameter int DEFAULT_DIV  = 325,
  parameter int DEFAULT_FRAC = 8
) (
  input logic         CLK,
  input logic         RST,
  cv_baud_gen_if.slave bus
);

  localparam logic [CNT_WDT-1:0]  DEF_DIV  = CNT_WDT'(DEFAULT_DIV);
  localparam logic [FRAC_WDT-1:0] DEF_FRAC = FRAC_WDT'(DEFAULT_FRAC);
  localparam logic [OVS_WDT-1:0]  OVS_LAST = OVS_WDT'(OVS_RATE - 1);
  localparam logic [OVS_WDT-1:0]  OVS_MID  = OVS_WDT'(OVS_RATE / 2 - 1);

  logic [CNT_WDT-1:0]  pcnt_q, pcnt_d;
  logic [OVS_WDT-1:0]  ocnt_q, ocnt_d;
  logic [FRAC_WDT-1:0] acc_q, acc_d;
  logic                ext_q, ext_d;
  logic [CNT_WDT-1:0]  div_active_q, div_active_d;
  logic [FRAC_WDT-1:0] frac_active_q, frac_active_d;
  logic [CNT_WDT-1:0]  shadow_div_q, shadow_div_d;
  logic [FRAC_WDT-1:0] shadow_frac_q, shadow_frac_d;
  logic                load_pend_q, load_pend_d;
  logic                ovs_q, ovs_d;
  logic                uart_q, uart_d;
  logic                mid_q, mid_d;

  logic [CNT_WDT:0]    period_m1;
  logic [FRAC_WDT:0]   sum;
  logic [CNT_WDT-1:0]  div_in_fix;
  logic                wrap;
  logic                apply_evt;

  // Compare one bit wider so a full 2^CNT_WDT period (max div plus carry) still wraps.
  assign period_m1  = {1'b0, div_active_q} + {{CNT_WDT{1'b0}}, ext_q} - {{CNT_WDT{1'b0}}, 1'b1};
  assign wrap       = bus.EN && ({1'b0, pcnt_q} == period_m1);
  assign sum        = {1'b0, acc_q} + {1'b0, frac_active_q};
  assign div_in_fix = (bus.DIV_IN == '0) ? CNT_WDT'(1) : bus.DIV_IN;
  assign apply_evt  = bus.RESYNC || !bus.EN || wrap;

  always_comb begin
    pcnt_d        = pcnt_q;
    ocnt_d        = ocnt_q;
    acc_d         = acc_q;
    ext_d         = ext_q;
    div_active_d  = div_active_q;
    frac_active_d = frac_active_q;
    shadow_div_d  = shadow_div_q;
    shadow_frac_d = shadow_frac_q;
    load_pend_d   = load_pend_q;
    ovs_d         = 1'b0;
    uart_d        = 1'b0;
    mid_d         = 1'b0;

    // A write landing on an apply edge bypasses the shadow and never shows as pending.
    if (bus.DIV_WE) begin
      shadow_div_d  = div_in_fix;
      shadow_frac_d = bus.FRAC_IN;
      if (apply_evt) begin
        div_active_d  = div_in_fix;
        frac_active_d = bus.FRAC_IN;
        load_pend_d   = 1'b0;
      end else begin
        load_pend_d   = 1'b1;
      end
    end else if (load_pend_q && apply_evt) begin
      div_active_d  = shadow_div_q;
      frac_active_d = shadow_frac_q;
      load_pend_d   = 1'b0;
    end

    if (bus.RESYNC) begin
      pcnt_d = '0;
      ocnt_d = '0;
      acc_d  = '0;
      ext_d  = 1'b0;
    end else if (!bus.EN) begin
      pcnt_d = pcnt_q;
    end else if (wrap) begin
      pcnt_d = '0;
      acc_d  = sum[FRAC_WDT-1:0];
      ext_d  = sum[FRAC_WDT];
      ocnt_d = (ocnt_q == OVS_LAST) ? '0 : ocnt_q + OVS_WDT'(1);
      ovs_d  = 1'b1;
      uart_d = (ocnt_q == OVS_LAST);
      mid_d  = (ocnt_q == OVS_MID);
    end else begin
      pcnt_d = pcnt_q + CNT_WDT'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt_q        <= '0;
      ocnt_q        <= '0;
      acc_q         <= '0;
      ext_q         <= 1'b0;
      div_active_q  <= DEF_DIV;
      frac_active_q <= DEF_FRAC;
      shadow_div_q  <= DEF_DIV;
      shadow_frac_q <= DEF_FRAC;
      load_pend_q   <= 1'b0;
      ovs_q         <= 1'b0;
      uart_q        <= 1'b0;
      mid_q         <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      ocnt_q        <= ocnt_d;
      acc_q         <= acc_d;
      ext_q         <= ext_d;
      div_active_q  <= div_active_d;
      frac_active_q <= frac_active_d;
      shadow_div_q  <= shadow_div_d;
      shadow_frac_q <= shadow_frac_d;
      load_pend_q   <= load_pend_d;
      ovs_q         <= ovs_d;
      uart_q        <= uart_d;
      mid_q         <= mid_d;
    end
  end

  assign bus.OVS_CE     = ovs_q;
  assign bus.UART_CE    = uart_q;
  assign bus.MID_CE     = mid_q;
  assign bus.LOAD_PEND  = load_pend_q;
  assign bus.DIV_ACTIVE = div_active_q;

endmodule

// File: doc/cv_baud_gen.md
Name: cv_baud_gen

Overview:
Parametrised UART timing generator that replaces the fixed divider.
- Runtime-programmable integer divisor plus a fractional accumulator, for accurate baud rates from arbitrary clocks.
- Produces an oversample strobe, a bit-rate strobe and a mid-bit sample strobe.
- Sits between the system clock and the UART TX/RX cores. RX drives RESYNC on the start-bit edge to phase-align sampling.

Parameters:
CNT_WDT, 16, width of prescaler counter and divisor.
FRAC_WDT, 4, width of fractional part; fraction = FRAC/2^FRAC_WDT.
OVS_RATE, 16, oversample ticks per bit; even, >=2.
OVS_WDT, 4, width of oversample counter; OVS_RATE <= 2^OVS_WDT.
DEFAULT_DIV, 325, integer divisor after reset (50 MHz, 9600 baud, x16).
DEFAULT_FRAC, 8, fractional divisor after reset.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous active-high reset.
EN  in  1  count enable.
DIV_IN  in  CNT_WDT  integer clocks per oversample tick.
FRAC_IN  in  FRAC_WDT  fractional clocks per oversample tick.
DIV_WE  in  1  one-cycle load strobe for DIV_IN/FRAC_IN.
RESYNC  in  1  restart bit phase.
OVS_CE  out  1  one-cycle pulse per oversample period.
UART_CE  out  1  one-cycle pulse per bit (every OVS_RATE OVS_CE).
MID_CE  out  1  one-cycle pulse at mid-bit sample point.
LOAD_PEND  out  1  shadow divisor waiting to be applied.
DIV_ACTIVE  out  CNT_WDT  integer divisor currently in use.

Behaviour:
Reset and priority
- Single clock domain. All state is updated on posedge CLK.
- Priority order: RST > RESYNC > EN=0 > normal.
- RST state: pcnt=0, ocnt=0, acc=0, ext=0, div_active=DEFAULT_DIV, frac_active=DEFAULT_FRAC, shadow=defaults.
- RST outputs: OVS_CE=UART_CE=MID_CE=LOAD_PEND=0, DIV_ACTIVE=DEFAULT_DIV.

Prescaler
- pcnt counts 0..P-1, with P = div_active + ext. Compare is done CNT_WDT+1 wide, so P=2^CNT_WDT is legal.
- Wrap means pcnt==P-1 with EN=1. On wrap: pcnt<=0; sum=acc+frac_active; acc<=sum[FRAC_WDT-1:0]; ext<=sum[FRAC_WDT]. The new ext sets the next period.
- Average period = div + frac/2^FRAC_WDT clocks.

Strobes
- All strobes are registered. OVS_CE<=1 on the wrap edge, so it is high for the cycle after the edge where pcnt was P-1. First OVS_CE follows the P-th enabled edge after reset.
- On wrap, ocnt<=(ocnt==OVS_RATE-1)?0:ocnt+1.
- UART_CE<=1 on a wrap with ocnt==OVS_RATE-1.
- MID_CE<=1 on a wrap with ocnt==OVS_RATE/2-1.
- Strobes are 0 in every other cycle. UART_CE and MID_CE are always coincident with OVS_CE.

Divisor load
- DIV_WE writes the shadow and sets LOAD_PEND. DIV_IN=0 is stored as 1.
- A pending shadow is applied (div_active/frac_active updated, LOAD_PEND cleared) at the next wrap, RESYNC, or any edge with EN=0.
- DIV_WE on the same edge as a wrap, RESYNC or EN=0: the new value is applied directly and LOAD_PEND stays 0.
- A second DIV_WE while pending overwrites the shadow.
- acc is not cleared by a load.
- DIV_ACTIVE updates on the same edge the shadow is applied.

RESYNC
- Clears pcnt, ocnt, acc and ext, and applies any pending load.
- All strobes are 0 in the following cycle.
- Counting restarts at 0 on the next edge if EN=1.
- MID_CE then falls on the (OVS_RATE/2)-th OVS_CE after RESYNC; UART_CE falls on the OVS_RATE-th.

EN=0
- pcnt, ocnt, acc and ext hold. Strobes are 0.
- When EN returns to 1, counting resumes from the held values.

Test Plan:
1. Params CNT_WDT=8, OVS_RATE=4, OVS_WDT=2, DEFAULT_DIV=5, DEFAULT_FRAC=0; release RST, EN=1 -> all outputs 0 during reset; OVS_CE every 5 cycles, first one after the 5th edge; UART_CE every 20 cycles with the 4th OVS_CE; MID_CE with the 2nd, 6th, 10th ... OVS_CE.
2. DIV_IN=3, FRAC_IN=4 loaded with EN=0, then EN=1 -> OVS_CE intervals 3,3,3,3,4 then repeating 3,3,3,4; exactly 4 OVS_CE per 13 cycles in steady state.
3. DIV=5, DIV_WE with DIV_IN=7 when pcnt=2 -> LOAD_PEND=1 until the next wrap; that period stays 5 clocks; following intervals are 7; DIV_ACTIVE reads 7 from the wrap edge.
4. DIV_WE with DIV_IN=0, FRAC_IN=0 -> DIV_ACTIVE=1; OVS_CE high every cycle once applied; UART_CE every 4 cycles.
5. RESYNC asserted mid-bit (ocnt=3, pcnt=1) -> all strobes 0 in the next cycle; MID_CE on the 2nd and UART_CE on the 4th subsequent OVS_CE (10 and 20 clocks after counting restarts).
6. EN low for 7 cycles at pcnt=3 -> no strobes and counters frozen; the next OVS_CE arrives 2 enabled cycles after EN rises. RST pulsed mid-period -> all outputs 0 on the next edge and the defaults are restored.
